// File: rtl/set_host_seq.sv
// set_host_seq: host-side job sequencer that replays pattern-ROM jobs into SET and scores the results.
// Optional build macro STOP_ON_FAIL_EN ends the run right after the first failing job.
module set_host_seq #(
    parameter int NUM_JOBS = 16,
    parameter int ADDR_W   = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [45:0]       rom_data,
    output logic              en,
    output logic [23:0]       central,
    output logic [11:0]       radius,
    output logic [1:0]        mode,
    input  logic              busy,
    input  logic              valid,
    input  logic [7:0]        candidate,
    output logic              run_busy,
    output logic              done,
    output logic [ADDR_W:0]   pass_cnt,
    output logic [ADDR_W:0]   fail_cnt,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic              timeout_flag
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_GAP, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_JOBS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1'b1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1'b1);
    localparam logic [15:0]       TIMEOUT_W = 16'(TIMEOUT);

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   index_r;
    logic [15:0]         timer_r;
    logic [15:0]         timer_next_s;
    logic [7:0]          expected_r;
    logic [7:0]          cand_r;
    logic                job_timeout_r;
    logic                timeout_hit_s;
    logic                job_match_s;
    logic                stop_s;
    logic                en_r, done_r, run_busy_r, timeout_flag_r;
    logic [23:0]         central_r;
    logic [11:0]         radius_r;
    logic [1:0]          mode_r;
    logic [ADDR_W:0]     pass_cnt_r, fail_cnt_r;
    logic [ADDR_W-1:0]   first_fail_idx_r;

    // Job scoring terms; the timer value here is the count of cycles elapsed since en.
    always_comb begin
        timer_next_s  = timer_r + 16'd1;
        timeout_hit_s = (timer_next_s == TIMEOUT_W);
        job_match_s   = (!job_timeout_r) && (cand_r == expected_r);
    end

    // Early-termination request: only the stop-on-fail build ends a run before the last job.
    always_comb begin
`ifdef STOP_ON_FAIL_EN
        stop_s = (fail_cnt_r != {(ADDR_W + 1){1'b0}});
`else
        stop_s = 1'b0;
`endif
    end

    // Next-state logic; a valid coinciding with the timeout cycle still wins over the timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  if (start) state_s = S_FETCH; else state_s = S_IDLE;
            S_FETCH: state_s = S_LOAD;
            S_LOAD:  state_s = S_ISSUE;
            S_ISSUE: state_s = S_WAIT;
            S_WAIT:  if (valid || timeout_hit_s) state_s = S_CHECK; else state_s = S_WAIT;
            S_CHECK: state_s = S_GAP;
            S_GAP: begin
                if (!busy && !valid) begin
                    if ((index_r == LAST_IDX) || stop_s) state_s = S_DONE;
                    else                                state_s = S_FETCH;
                end else begin
                    state_s = S_GAP;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_s;
    end

    // Datapath and registered outputs, updated according to the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_r          <= '0;
            timer_r          <= '0;
            expected_r       <= '0;
            cand_r           <= '0;
            job_timeout_r    <= 1'b0;
            en_r             <= 1'b0;
            done_r           <= 1'b0;
            run_busy_r       <= 1'b0;
            timeout_flag_r   <= 1'b0;
            central_r        <= '0;
            radius_r         <= '0;
            mode_r           <= '0;
            pass_cnt_r       <= '0;
            fail_cnt_r       <= '0;
            first_fail_idx_r <= '0;
        end else begin
            en_r   <= (state_r == S_LOAD);
            done_r <= (state_r == S_GAP) && (state_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        run_busy_r       <= 1'b1;
                        index_r          <= '0;
                        pass_cnt_r       <= '0;
                        fail_cnt_r       <= '0;
                        first_fail_idx_r <= '0;
                        timeout_flag_r   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    central_r  <= rom_data[45:22];
                    radius_r   <= rom_data[21:10];
                    mode_r     <= rom_data[9:8];
                    expected_r <= rom_data[7:0];
                end
                S_ISSUE: begin
                    timer_r       <= '0;
                    job_timeout_r <= 1'b0;
                end
                S_WAIT: begin
                    timer_r <= timer_next_s;
                    if (valid) begin
                        cand_r <= candidate;
                    end else if (timeout_hit_s) begin
                        job_timeout_r  <= 1'b1;
                        timeout_flag_r <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (job_match_s) begin
                        pass_cnt_r <= pass_cnt_r + CNT_ONE;
                    end else begin
                        fail_cnt_r <= fail_cnt_r + CNT_ONE;
                        if (fail_cnt_r == {(ADDR_W + 1){1'b0}}) first_fail_idx_r <= index_r;
                    end
                end
                S_GAP: begin
                    if (state_s == S_FETCH)     index_r    <= index_r + IDX_ONE;
                    else if (state_s == S_DONE) run_busy_r <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_addr       = index_r;
    assign en             = en_r;
    assign central        = central_r;
    assign radius         = radius_r;
    assign mode           = mode_r;
    assign run_busy       = run_busy_r;
    assign done           = done_r;
    assign pass_cnt       = pass_cnt_r;
    assign fail_cnt       = fail_cnt_r;
    assign first_fail_idx = first_fail_idx_r;
    assign timeout_flag   = timeout_flag_r;

endmodule

// File: tb/tb_set_host_seq.sv
// Self-checking bench for set_host_seq: synchronous ROM, behavioural SET responder and a job-level timing/score model.
module tb_set_host_seq;
    localparam int NJ = 16;
    localparam int AW = 4;
    localparam int TO = 20;
`ifdef STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start;
    logic [AW-1:0] rom_addr;
    logic [45:0]   rom_data;
    logic          en;
    logic [23:0]   central;
    logic [11:0]   radius;
    logic [1:0]    mode;
    logic          busy, valid;
    logic [7:0]    candidate;
    logic          run_busy, done;
    logic [AW:0]   pass_cnt, fail_cnt;
    logic [AW-1:0] first_fail_idx;
    logic          timeout_flag;

    set_host_seq #(.NUM_JOBS(NJ), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .en(en), .central(central), .radius(radius), .mode(mode), .busy(busy),
        .valid(valid), .candidate(candidate), .run_busy(run_busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bad;
        logic [15:0] tmo;
        int          dly;
        int          hold;
        int          exp_pass;
        int          exp_fail;
        int          exp_ffi;
        bit          exp_tf;
    } vec_t;

    logic [45:0] rom [NJ];
    logic [7:0]  resp_cand [NJ];
    int          resp_dly [NJ];
    int          resp_hold [NJ];

    int cyc = 0;
    int job_ptr = 0;
    int rb_cnt = 0;
    int n_vec = 0;
    int n_err = 0;
    int en_seen[$];
    int done_seen[$];
    int m_en[$];
    int m_done, m_pass, m_fail, m_ffi;
    bit m_tf;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural SET: valid+candidate resp_dly cycles after en (0 = never), busy until resp_hold cycles after valid.
    initial begin : responder
        int  due, busy_from, busy_until, j;
        bit  pend;
        logic [7:0] cand_q;
        valid = 1'b0; busy = 1'b0; candidate = 8'd0;
        pend = 1'b0; due = 0; busy_from = 0; busy_until = -1; j = 0; cand_q = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                pend = 1'b0; valid = 1'b0; busy = 1'b0; busy_until = -1;
            end else begin
                valid = 1'b0;
                if (pend && cyc == due) begin
                    valid = 1'b1; candidate = cand_q; pend = 1'b0;
                    chk("hold_central", int'(central), int'(rom[j][45:22]));
                    chk("hold_radius_mode", int'({radius, mode}), int'(rom[j][21:8]));
                end
                if (en === 1'b1) begin
                    j = job_ptr; job_ptr++;
                    if (j < NJ) begin
                        chk("issue_central", int'(central), int'(rom[j][45:22]));
                        chk("issue_radius_mode", int'({radius, mode}), int'(rom[j][21:8]));
                        if (resp_dly[j] != 0) begin
                            pend = 1'b1; due = cyc + resp_dly[j]; cand_q = resp_cand[j];
                            busy_from = cyc + 1; busy_until = cyc + resp_dly[j] + resp_hold[j];
                        end
                    end
                end
                busy = (cyc >= busy_from) && (cyc <= busy_until);
            end
        end
    end

    // Observer: records en/done cycles and counts run_busy-high cycles.
    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            if (en === 1'b1)       en_seen.push_back(cyc);
            if (done === 1'b1)     done_seen.push_back(cyc);
            if (run_busy === 1'b1) rb_cnt++;
        end
    end

    // Job-level reference: en of first job 3 cycles after start; each job's response (or timeout)
    // is scored, the inter-job gap lasts at least one cycle and until busy drops, then 3 cycles to next en.
    task automatic model_run();
        int e, d, ra, bl, c;
        bit ok, tm;
        m_en.delete(); m_pass = 0; m_fail = 0; m_ffi = 0; m_tf = 1'b0; m_done = 0;
        e = 3;
        for (int j = 0; j < NJ; j++) begin
            m_en.push_back(e);
            d  = resp_dly[j];
            tm = (d == 0);
            ok = !tm && (resp_cand[j] == rom[j][7:0]);
            if (ok) m_pass++;
            else begin
                if (m_fail == 0) m_ffi = j;
                m_fail++;
                if (tm) m_tf = 1'b1;
            end
            ra = tm ? e + TO : e + d;
            bl = tm ? 0 : e + d + resp_hold[j] + 1;
            c  = (ra + 2 > bl) ? ra + 2 : bl;
            if (j == NJ - 1 || (STOP && !ok)) begin
                m_done = c + 1;
                break;
            end
            e = c + 3;
        end
    endtask

    task automatic setup_tbl(input vec_t v);
        for (int j = 0; j < NJ; j++) begin
            rom[j]       = {24'($urandom), 12'($urandom), 2'($urandom), 8'($urandom)};
            resp_cand[j] = rom[j][7:0] + (v.bad[j] ? 8'd1 : 8'd0);
            resp_dly[j]  = v.tmo[j] ? 0 : v.dly;
            resp_hold[j] = v.hold;
        end
    endtask

    task automatic setup_rand();
        for (int j = 0; j < NJ; j++) begin
            rom[j]       = {24'($urandom), 12'($urandom), 2'($urandom), 8'($urandom)};
            resp_cand[j] = rom[j][7:0] + (($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
            resp_dly[j]  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
            resp_hold[j] = int'($urandom_range(0, 12));
        end
    endtask

    // One full run with stray starts mid-run and in the done cycle; checks timing and final scores.
    task automatic run_once(input string tag, input bit use_tbl, input int ep, input int ef,
                            input int effi, input bit etf);
        int s, n;
        model_run();
        if (!use_tbl) begin
            ep = m_pass; ef = m_fail; effi = m_ffi; etf = m_tf;
        end
        job_ptr = 0; en_seen.delete(); done_seen.delete(); rb_cnt = 0;
        s = cyc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < s + m_done + 4) begin
            @(posedge clk); #1;
            start = (cyc == s + m_done / 2) || (cyc == s + m_done);
        end
        start = 1'b0;
        chk({tag, "_en_count"}, en_seen.size(), m_en.size());
        n = (en_seen.size() < m_en.size()) ? en_seen.size() : m_en.size();
        for (int i = 0; i < n; i++) chk({tag, "_en_cycle"}, en_seen[i] - s, m_en[i]);
        chk({tag, "_done_count"}, done_seen.size(), 1);
        if (done_seen.size() > 0) chk({tag, "_done_cycle"}, done_seen[0] - s, m_done);
        chk({tag, "_run_busy_cycles"}, rb_cnt, m_done - 1);
        chk({tag, "_pass_cnt"}, int'(pass_cnt), ep);
        chk({tag, "_fail_cnt"}, int'(fail_cnt), ef);
        chk({tag, "_first_fail_idx"}, int'(first_fail_idx), effi);
        chk({tag, "_timeout_flag"}, int'(timeout_flag), int'(etf));
    endtask

    vec_t tbl [6];

    initial begin : main
        int k;
        tbl[0] = '{16'h0000, 16'h0000, 3, 0, 16, 0, 0, 1'b0};
        tbl[1] = '{16'h0220, 16'h0000, 2, 1, STOP ? 5 : 14, STOP ? 1 : 2, 5, 1'b0};
        tbl[2] = '{16'h0000, 16'h0004, 4, 0, STOP ? 2 : 15, 1, 2, 1'b1};
        tbl[3] = '{16'h0000, 16'h0000, TO, 0, 16, 0, 0, 1'b0};
        tbl[4] = '{16'h0001, 16'h8000, 1, 10, STOP ? 0 : 14, STOP ? 1 : 2, 0, STOP ? 1'b0 : 1'b1};
        tbl[5] = '{16'h8000, 16'h0000, 5, 10, 15, 1, 15, 1'b0};
        for (int j = 0; j < NJ; j++) begin
            rom[j] = 46'd0; resp_cand[j] = 8'd0; resp_dly[j] = 1; resp_hold[j] = 0;
        end

        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_set_bits", $countones({en, done, run_busy, pass_cnt, fail_cnt, first_fail_idx,
            timeout_flag, rom_addr, central, radius, mode}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            setup_tbl(tbl[v]);
            run_once($sformatf("tbl%0d", v), 1'b1, tbl[v].exp_pass, tbl[v].exp_fail, tbl[v].exp_ffi, tbl[v].exp_tf);
        end

        for (int r = 0; r < 6; r++) begin
            setup_rand();
            run_once($sformatf("rnd%0d", r), 1'b0, 0, 0, 0, 1'b0);
        end

        // Reset while job 7 waits for a response that never comes.
        setup_tbl(tbl[0]);
        resp_dly[7] = 0;
        job_ptr = 0; en_seen.delete(); done_seen.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (en_seen.size() < 8 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_reach_job7", en_seen.size(), 8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_pass_cnt", int'(pass_cnt), 7);
        chk("pre_rst_run_busy", int'(run_busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_outputs_set_bits", $countones({en, done, run_busy, pass_cnt, fail_cnt, first_fail_idx,
            timeout_flag, rom_addr, central, radius, mode}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
        end
        chk("rst_no_done", done_seen.size(), 0);
        chk("rst_no_more_en", en_seen.size(), 8);

        setup_tbl(tbl[1]);
        run_once("rerun", 1'b1, tbl[1].exp_pass, tbl[1].exp_fail, tbl[1].exp_ffi, tbl[1].exp_tf);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
